// File: rtl/mac_sequencer.sv
// Sequencer for one signed MAC: clear, stream len weight/input pairs from two sync memories, latch and hand off result.
// Build option NEURON_RELU_EN: clamp negative results to zero when latching.
module mac_sequencer #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ACC_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] len,
  input  logic [ADDR_WIDTH-1:0] w_base,
  input  logic [ADDR_WIDTH-1:0] x_base,
  output logic                  busy,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] w_addr,
  output logic [ADDR_WIDTH-1:0] x_addr,
  input  logic [DATA_WIDTH-1:0] w_rdata,
  input  logic [DATA_WIDTH-1:0] x_rdata,
  output logic                  mac_clear,
  output logic                  mac_enable,
  output logic [DATA_WIDTH-1:0] mac_weight,
  output logic [DATA_WIDTH-1:0] mac_input,
  input  logic [ACC_WIDTH-1:0]  mac_acc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ACC_WIDTH-1:0]  out_data
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FETCH,
    S_DRAIN,
    S_LATCH,
    S_OUTPUT
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] IDX_ONE = 1;

  state_t                r_state;
  state_t                w_state_next;
  logic [ADDR_WIDTH-1:0] r_len;
  logic [ADDR_WIDTH-1:0] r_w_base;
  logic [ADDR_WIDTH-1:0] r_x_base;
  logic [ADDR_WIDTH-1:0] r_idx;
  logic                  r_busy;
  logic                  r_mem_rd_en;
  logic [ADDR_WIDTH-1:0] r_w_addr;
  logic [ADDR_WIDTH-1:0] r_x_addr;
  logic                  r_mac_clear;
  logic                  r_mac_enable;
  logic                  r_out_valid;
  logic [ACC_WIDTH-1:0]  r_out_data;
  logic [ACC_WIDTH-1:0]  w_latch_val;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_next;
  end

  // r_idx counts reads already issued, so FETCH ends once it reaches len.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      S_IDLE:   if (start) w_state_next = S_CLEAR;
      S_CLEAR:  w_state_next = (r_len != '0) ? S_FETCH : S_LATCH;
      S_FETCH:  if (r_idx == r_len) w_state_next = S_DRAIN;
      S_DRAIN:  w_state_next = S_LATCH;
      S_LATCH:  w_state_next = S_OUTPUT;
      S_OUTPUT: if (out_ready) w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

`ifdef NEURON_RELU_EN
  assign w_latch_val = mac_acc[ACC_WIDTH-1] ? '0 : mac_acc;
`else
  assign w_latch_val = mac_acc;
`endif

  // Outputs are decoded from the next state so they are registered yet aligned with the state they belong to.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_len        <= '0;
      r_w_base     <= '0;
      r_x_base     <= '0;
      r_idx        <= '0;
      r_busy       <= 1'b0;
      r_mem_rd_en  <= 1'b0;
      r_w_addr     <= '0;
      r_x_addr     <= '0;
      r_mac_clear  <= 1'b0;
      r_mac_enable <= 1'b0;
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
    end else begin
      if (r_state == S_IDLE && start) begin
        r_len    <= len;
        r_w_base <= w_base;
        r_x_base <= x_base;
        r_idx    <= '0;
      end
      if (w_state_next == S_FETCH) begin
        r_w_addr <= r_w_base + r_idx;
        r_x_addr <= r_x_base + r_idx;
        r_idx    <= r_idx + IDX_ONE;
      end
      if (r_state == S_LATCH) r_out_data <= w_latch_val;
      r_busy       <= (w_state_next != S_IDLE);
      r_mem_rd_en  <= (w_state_next == S_FETCH);
      r_mac_clear  <= (w_state_next == S_CLEAR);
      r_mac_enable <= r_mem_rd_en;
      r_out_valid  <= (w_state_next == S_OUTPUT);
    end
  end

  assign busy       = r_busy;
  assign mem_rd_en  = r_mem_rd_en;
  assign w_addr     = r_w_addr;
  assign x_addr     = r_x_addr;
  assign mac_clear  = r_mac_clear;
  assign mac_enable = r_mac_enable;
  assign mac_weight = w_rdata;
  assign mac_input  = x_rdata;
  assign out_valid  = r_out_valid;
  assign out_data   = r_out_data;

endmodule

// File: tb/tb_mac_sequencer.sv
// Bench for mac_sequencer: behavioural memories and MAC around the DUT, dot products checked against plain arithmetic.
module tb_mac_sequencer;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              start;
  logic [7:0]        len;
  logic [7:0]        w_base;
  logic [7:0]        x_base;
  logic              busy;
  logic              mem_rd_en;
  logic [7:0]        w_addr;
  logic [7:0]        x_addr;
  logic [7:0]        w_rdata;
  logic [7:0]        x_rdata;
  logic              mac_clear;
  logic              mac_enable;
  logic [7:0]        mac_weight;
  logic [7:0]        mac_input;
  logic [31:0]       mac_acc;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_data;

  logic signed [7:0] wmem [256];
  logic signed [7:0] xmem [256];
  int                n_checks = 0;
  int                n_errors = 0;

  always #5 clk = ~clk;

  mac_sequencer #(.DATA_WIDTH(8), .ACC_WIDTH(32), .ADDR_WIDTH(8)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .len(len),
    .w_base(w_base), .x_base(x_base), .busy(busy), .mem_rd_en(mem_rd_en),
    .w_addr(w_addr), .x_addr(x_addr), .w_rdata(w_rdata), .x_rdata(x_rdata),
    .mac_clear(mac_clear), .mac_enable(mac_enable), .mac_weight(mac_weight),
    .mac_input(mac_input), .mac_acc(mac_acc), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data)
  );

  // Synchronous operand memories and the MAC datapath the sequencer drives.
  always @(posedge clk) begin
    if (mem_rd_en) begin
      w_rdata <= wmem[w_addr];
      x_rdata <= xmem[x_addr];
    end
    if (mac_clear)
      mac_acc <= '0;
    else if (mac_enable)
      mac_acc <= mac_acc + 32'(int'($signed(mac_weight)) * int'($signed(mac_input)));
  end

  function automatic logic [31:0] ref_dot(input int n, input int wb, input int xb);
    longint      s;
    logic [31:0] r;
    s = 0;
    for (int k = 0; k < n; k++)
      s += longint'(wmem[(wb + k) % 256]) * longint'(xmem[(xb + k) % 256]);
    r = s[31:0];
`ifdef NEURON_RELU_EN
    if (r[31]) r = '0;
`endif
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  task automatic run_job(input int n, input int wb, input int xb, input int hold);
    int          reads, ens, clrs, vcyc, cyc;
    logic [31:0] exp, held;
    exp = ref_dot(n, wb, xb);
    out_ready = (hold == 0);
    @(negedge clk);
    check("idle_busy", {31'b0, busy}, 0);
    start = 1'b1; len = n[7:0]; w_base = wb[7:0]; x_base = xb[7:0];
    @(negedge clk);
    start = 1'b0;
    cyc = 1; reads = 0; ens = 0; clrs = 0; vcyc = -1;
    while (vcyc < 0 && cyc < n + 40) begin
      check("clr_en_excl", {31'b0, mac_clear & mac_enable}, 0);
      if (mac_clear) clrs++;
      if (mac_enable) ens++;
      if (mem_rd_en) begin
        check("w_addr", {24'b0, w_addr}, (wb + reads) % 256);
        check("x_addr", {24'b0, x_addr}, (xb + reads) % 256);
        check("rd_cycle", cyc, reads + 2);
        reads++;
      end
      if (out_valid) vcyc = cyc;
      else begin
        @(negedge clk);
        cyc++;
      end
    end
    check("valid_cycle", vcyc, (n == 0) ? 3 : n + 4);
    check("read_count", reads, n);
    check("enable_count", ens, n);
    check("clear_count", clrs, 1);
    check("out_data", out_data, exp);
    held = out_data;
    for (int i = 0; i < hold; i++) begin
      start = 1'b1;
      len = 8'($urandom_range(1, 9));
      @(negedge clk);
      check("bp_valid", {31'b0, out_valid}, 1);
      check("bp_busy", {31'b0, busy}, 1);
      check("bp_data", out_data, held);
    end
    start = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("post_valid", {31'b0, out_valid}, 0);
    check("post_busy", {31'b0, busy}, 0);
    check("post_clear", {31'b0, mac_clear}, 0);
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; len = '0; w_base = '0; x_base = '0; out_ready = 1'b0;
    for (int i = 0; i < 256; i++) begin
      wmem[i] = 8'($urandom);
      xmem[i] = 8'($urandom);
    end
    repeat (3) @(negedge clk);
    check("rst_busy", {31'b0, busy}, 0);
    check("rst_rd_en", {31'b0, mem_rd_en}, 0);
    check("rst_valid", {31'b0, out_valid}, 0);
    check("rst_data", out_data, 0);
    reset_n = 1'b1;

    for (int i = 0; i < 4; i++) begin
      wmem[i] = 8'(i + 1);
      xmem[i] = 8'(i + 5);
    end
    run_job(4, 0, 0, 0);
    check("basic_70", out_data, 70);

    wmem[10] = -8'sd3; xmem[20] = 8'sd5;
    run_job(1, 10, 20, 0);
`ifdef NEURON_RELU_EN
    check("neg_relu", out_data, 0);
`else
    check("neg_m15", out_data, 32'hFFFF_FFF1);
`endif

    wmem[30] = -8'sd128; wmem[31] = -8'sd128; xmem[40] = -8'sd128; xmem[41] = -8'sd128;
    run_job(2, 30, 40, 0);
    check("max_32768", out_data, 32768);

    run_job(0, 7, 9, 0);
    check("zero_len", out_data, 0);

    run_job(3, 50, 60, 5);
    run_job(4, 254, 3, 0);

    // Reset in cycle 3 of a len=8 job, then an independent job.
    out_ready = 1'b1;
    @(negedge clk);
    start = 1'b1; len = 8'd8; w_base = 8'd100; x_base = 8'd120;
    repeat (3) @(negedge clk);
    start = 1'b0;
    check("pre_rst_rd_en", {31'b0, mem_rd_en}, 1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_busy", {31'b0, busy}, 0);
    check("mid_rst_rd_en", {31'b0, mem_rd_en}, 0);
    check("mid_rst_addr", {16'b0, w_addr, x_addr}, 0);
    check("mid_rst_mac", {30'b0, mac_clear, mac_enable}, 0);
    check("mid_rst_out", {31'b0, out_valid}, 0);
    check("mid_rst_data", out_data, 0);
    @(negedge clk);
    reset_n = 1'b1;
    run_job(6, 130, 140, 0);

    for (int j = 0; j < 6; j++)
      run_job(int'($urandom_range(0, 24)), int'($urandom_range(0, 255)),
              int'($urandom_range(0, 255)), int'($urandom_range(0, 3)));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/mac_sequencer.md
# mac_sequencer

Control sequencer for one signed multiply-accumulate unit. On a start command it clears the accumulator, then streams a dot product of length `len` by reading paired weight/input words from two synchronous memories. It feeds each pair to the MAC with an enable pulse, captures the final accumulated value and presents it on a valid/ready output. It sits between the layer scheduler, which issues start/len/base addresses, and a single MAC datapath.

## Interface
- `DATA_WIDTH`, 8, signed operand width of weights and inputs.
- `ACC_WIDTH`, 32, signed accumulator/result width.
- `ADDR_WIDTH`, 8, address width of both operand memories; also the width of `len`.

Ports:
- `clk` in 1: clock, rising edge.
- `reset_n` in 1: reset, asynchronous, active-low.
- `start` in 1: command strobe; accepted only in IDLE.
- `len` in ADDR_WIDTH: vector length, 0..2^ADDR_WIDTH-1; latched on accept.
- `w_base` in ADDR_WIDTH: weight memory base address; latched on accept.
- `x_base` in ADDR_WIDTH: input memory base address; latched on accept.
- `busy` out 1: high in every state except IDLE.
- `mem_rd_en` out 1: read strobe shared by both memories.
- `w_addr` out ADDR_WIDTH: weight read address.
- `x_addr` out ADDR_WIDTH: input read address.
- `w_rdata` in DATA_WIDTH: weight read data, valid one cycle after `mem_rd_en`.
- `x_rdata` in DATA_WIDTH: input read data, valid one cycle after `mem_rd_en`.
- `mac_clear` out 1: accumulator clear to the MAC.
- `mac_enable` out 1: accumulate strobe to the MAC.
- `mac_weight` out DATA_WIDTH: operand to the MAC; equals `w_rdata`.
- `mac_input` out DATA_WIDTH: operand to the MAC; equals `x_rdata`.
- `mac_acc` in ACC_WIDTH: MAC accumulator value, registered inside the MAC.
- `out_valid` out 1: result available.
- `out_ready` in 1: consumer accepts the result.
- `out_data` out ACC_WIDTH: signed result.

## Operation
- States: IDLE, CLEAR, FETCH, DRAIN, LATCH, OUTPUT.
- IDLE:
  - `start`=1 latches len/bases, zeroes index `idx`, and moves to CLEAR.
  - `start` in any other state is ignored; no queueing.
- CLEAR: one cycle with `mac_clear`=1.
  - Goes to FETCH if len≠0.
  - Goes to LATCH if len=0, giving result 0.
- FETCH:
  - Asserts `mem_rd_en`=1, `w_addr`=w_base+idx, `x_addr`=x_base+idx, then increments idx.
  - Addresses wrap modulo 2^ADDR_WIDTH.
  - After issuing idx=len-1, moves to DRAIN.
- `mac_enable` is `mem_rd_en` delayed by one register stage. `mac_weight`/`mac_input` are wired directly from the read data.
- DRAIN: one cycle in which the last `mac_enable` is asserted; then LATCH.
- LATCH: captures `mac_acc` into `out_data` register; then OUTPUT.
- OUTPUT:
  - `out_valid`=1 with `out_data` stable.
  - On `out_valid`&&`out_ready`, goes to IDLE with `out_valid`=0 the next cycle.
  - `out_ready` outside OUTPUT is ignored.
- Arithmetic is done entirely in the MAC. The sequencer never modifies the value except through the configuration feature below.
- Reset, including mid-operation, returns to IDLE asynchronously. Reset values are 0 for all of: `busy`, `mem_rd_en`, `w_addr`, `x_addr`, `mac_clear`, `mac_enable`, `out_valid`, `out_data`, idx.
- `mac_clear` and `mac_enable` are never high in the same cycle.

## Timing
- Let the start-accept edge close cycle 0.
  - CLEAR is cycle 1.
  - FETCH spans cycles 2..len+1.
  - `mac_enable` is high during cycles 3..len+2.
  - DRAIN is cycle len+2.
  - LATCH is cycle len+3.
  - `out_valid` first rises in cycle len+4.
- For len=0: CLEAR in cycle 1, LATCH in cycle 2, `out_valid` in cycle 3.
- Throughput is one element per cycle, with no bubbles inside FETCH.
- Earliest next accept is the cycle after the output handshake, when the FSM is back in IDLE.
- All outputs are registered except `mac_weight`/`mac_input`, which are pass-through.

## Configuration
- `NEURON_RELU_EN`:
  - Defined: LATCH stores `mac_acc` if it is ≥0, otherwise 0 (ReLU).
  - Undefined: LATCH stores `mac_acc` unchanged, and negative results appear as two's complement.
- Timing is identical in both builds.

## Test plan
- **Basic dot product:** len=4, w=[1,2,3,4], x=[5,6,7,8], bases 0, `out_ready`=1 → `out_data`=70, `out_valid` in cycle 8, exactly 4 `mac_enable` cycles, `busy` low in cycle 9.
- **Negative result:** len=1, w=[-3], x=[5] → `out_data`=-15 without `NEURON_RELU_EN`, 0 with it. len=2, w=[-128,-128], x=[-128,-128] → 32768.
- **Zero length:** len=0 → no `mem_rd_en`, one `mac_clear`, `out_valid` in cycle 3 with `out_data`=0.
- **Backpressure:** `out_ready`=0 for 5 cycles after `out_valid` with `start` pulsed meanwhile → `out_data` held, `busy`=1, start ignored, single handshake then IDLE.
- **Address wrap:** ADDR_WIDTH=4, w_base=14, x_base=3, len=4 → `w_addr` sequence 14,15,0,1 and `x_addr` sequence 3,4,5,6.
- **Reset mid-FETCH:** `reset_n` low in cycle 3 of a len=8 job → all outputs 0 immediately. A new start after release produces a correct, independent result.
